// File: rtl/l2rcv_pkg.sv
// l2rcv_pkg: shared L2 bus definitions (command encodings, tag fields, line
// geometry) used by the L2 bus receiver and transmitter, plus receiver-local
// payload and state types.
package l2rcv_pkg;

    localparam int unsigned CMD_W        = 3;
    localparam int unsigned TAG_W        = 5;
    localparam int unsigned AGENT_W      = 2;
    localparam int unsigned TAG_AGENT_HI = 4;
    localparam int unsigned TAG_AGENT_LO = 3;
    localparam int unsigned BUS_ADDR_W   = 30;   // byte address bits [31:2]
    localparam int unsigned DATA_W       = 64;
    localparam int unsigned LINE_W       = 26;   // line address bits [31:6]
    localparam int unsigned BEAT_W       = 3;
    localparam int unsigned LINE_BEATS   = 8;
    localparam int unsigned PERF_W       = 16;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP  = 3'd0,
        CMD_RD   = 3'd1,
        CMD_RDX  = 3'd2,
        CMD_INV  = 3'd3,
        CMD_WB   = 3'd4,
        CMD_RESP = 3'd5,
        CMD_RSV6 = 3'd6,
        CMD_RSV7 = 3'd7
    } bus_cmd_e;

    // Snoop FIFO payload: command plus snooped line address.
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [LINE_W-1:0] line;
    } snp_entry_t;

    typedef enum logic [1:0] {
        FILL_IDLE    = 2'd0,
        FILL_COLLECT = 2'd1,
        FILL_DELIVER = 2'd2
    } fill_state_e;

    // Commands other agents issue that the L2 must observe.
    function automatic logic is_snoop_cmd(input logic [CMD_W-1:0] cmd);
        return (cmd == CMD_RD) || (cmd == CMD_RDX) ||
               (cmd == CMD_INV) || (cmd == CMD_WB);
    endfunction

    // Commands that occupy LINE_BEATS bus cycles.
    function automatic logic is_burst_cmd(input logic [CMD_W-1:0] cmd);
        return (cmd == CMD_WB) || (cmd == CMD_RESP);
    endfunction

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : PERF_W'(v + 1'b1);
    endfunction

endpackage

// File: rtl/l2rcv_snpq.sv
// l2rcv_snpq: synchronous FIFO holding captured snoops.
// Ports: clk, rst (sync, active-high); push/wdata write side; pop/rdata read
// side (rdata is the head entry, valid when !empty); full, empty status.
// Push while full and pop while empty are ignored.
module l2rcv_snpq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 29
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; empty gates any use of rdata.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            end
            if (do_pop) begin
                rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= CNT_W'(count + 1'b1);
                2'b01:   count <= CNT_W'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/l2rcv.sv
// l2rcv: L2 bus receiver. Watches every bus cycle, assembles 8-beat RESP line
// fills addressed to this agent and replays them to the L2 beat by beat, and
// queues coherence commands from other agents as snoops (NACKing when full).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bus_*                    bus cycle inputs (valid, wired-OR nack, cmd, tag,
//                            addr[31:2], data)
//   l2rcv_bus_nack           our combinational NACK contribution
//   l2rcv_l2_fill_*          fill beat stream to L2, l2_l2rcv_fill_ready
//   l2rcv_l2_snp_*           snoop stream to L2, l2_l2rcv_snp_ready
//   l2rcv_err                sticky protocol error
//   perf_fills/snoops/nacks  saturating event counters, only when
//                            L2RCV_PERF_EN is defined
module l2rcv
    import l2rcv_pkg::*;
#(
    parameter logic [1:0]  AGENT_ID  = 2'd0,
    parameter int unsigned SNP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_valid,
    input  logic                  bus_nack,
    input  logic [CMD_W-1:0]      bus_cmd,
    input  logic [TAG_W-1:0]      bus_tag,
    input  logic [BUS_ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0]     bus_data,
    output logic                  l2rcv_bus_nack,
    output logic                  l2rcv_l2_fill_valid,
    output logic [LINE_W-1:0]     l2rcv_l2_fill_addr,
    output logic [BEAT_W-1:0]     l2rcv_l2_fill_beat,
    output logic [DATA_W-1:0]     l2rcv_l2_fill_data,
    input  logic                  l2_l2rcv_fill_ready,
    output logic                  l2rcv_l2_snp_valid,
    output logic [CMD_W-1:0]      l2rcv_l2_snp_cmd,
    output logic [LINE_W-1:0]     l2rcv_l2_snp_addr,
    input  logic                  l2_l2rcv_snp_ready,
    output logic                  l2rcv_err
`ifdef L2RCV_PERF_EN
    ,
    output logic [PERF_W-1:0]     perf_fills,
    output logic [PERF_W-1:0]     perf_snoops,
    output logic [PERF_W-1:0]     perf_nacks
`endif
);

    // ------------------------------------------------------------------
    // Bus cycle decode
    // ------------------------------------------------------------------
    logic [AGENT_W-1:0]    tag_agent;
    logic                  own_tag;
    logic [LINE_W-1:0]     addr_line;
    logic [BEAT_W-1:0]     addr_beat;
    logic [BEAT_W-1:0]     burst_cnt;
    logic                  first_cycle;
    logic                  snoop_cand;
    logic                  unused_bits;

    assign tag_agent   = bus_tag[TAG_AGENT_HI:TAG_AGENT_LO];
    assign own_tag     = (tag_agent == AGENT_ID);
    assign addr_line   = bus_addr[BUS_ADDR_W-1:4];
    assign addr_beat   = bus_addr[3:1];
    assign first_cycle = (burst_cnt == '0);
    assign snoop_cand  = bus_valid && first_cycle && is_snoop_cmd(bus_cmd) && !own_tag;
    assign unused_bits = ^{bus_addr[0], bus_tag[TAG_AGENT_LO-1:0]};

    // Counts valid cycles inside a WB/RESP burst so only cycle 0 decodes
    // as a command; wraps back to 0 after the eighth cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (bus_valid) begin
            if (!first_cycle) begin
                burst_cnt <= BEAT_W'(burst_cnt + 1'b1);
            end else if (is_burst_cmd(bus_cmd)) begin
                burst_cnt <= BEAT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Snoop queue
    // ------------------------------------------------------------------
    snp_entry_t snq_wdata;
    snp_entry_t snq_rdata;
    logic       snq_push;
    logic       snq_pop;
    logic       snq_full;
    logic       snq_empty;

    // Full is the registered occupancy, so a same-cycle pop never frees
    // room for a push.
    assign l2rcv_bus_nack = snoop_cand && snq_full;
    assign snq_push       = snoop_cand && !bus_nack && !snq_full;
    assign snq_pop        = !snq_empty && l2_l2rcv_snp_ready;
    assign snq_wdata      = '{cmd: bus_cmd, line: addr_line};

    l2rcv_snpq #(
        .DEPTH (SNP_DEPTH),
        .WIDTH ($bits(snp_entry_t))
    ) u_snpq (
        .clk   (clk),
        .rst   (rst),
        .push  (snq_push),
        .wdata (snq_wdata),
        .pop   (snq_pop),
        .rdata (snq_rdata),
        .full  (snq_full),
        .empty (snq_empty)
    );

    // Snoop outputs are zero while the queue is empty.
    always_comb begin
        l2rcv_l2_snp_valid = !snq_empty;
        l2rcv_l2_snp_cmd   = '0;
        l2rcv_l2_snp_addr  = '0;
        if (!snq_empty) begin
            l2rcv_l2_snp_cmd  = snq_rdata.cmd;
            l2rcv_l2_snp_addr = snq_rdata.line;
        end
    end

    // ------------------------------------------------------------------
    // Fill assembly and delivery
    // ------------------------------------------------------------------
    fill_state_e           state;
    fill_state_e           next_state;
    logic [DATA_W-1:0]     line_buf [LINE_BEATS];
    logic [LINE_BEATS-1:0] beat_valid;
    logic [LINE_BEATS-1:0] beat_onehot;
    logic [LINE_W-1:0]     line_q;
    logic [BEAT_W-1:0]     deliver_beat;
    logic                  err_q;
    logic                  fill_hit;
    logic                  collecting;
    logic                  line_mismatch;
    logic                  dup_beat;
    logic                  beat_wr;
    logic                  fill_err;
    logic                  line_done;
    logic                  deliver_fire;
    logic                  deliver_last;

    assign fill_hit      = bus_valid && (bus_cmd == CMD_RESP) && own_tag;
    assign collecting    = (state == FILL_IDLE) || (state == FILL_COLLECT);
    assign line_mismatch = (state == FILL_COLLECT) && (addr_line != line_q);
    assign dup_beat      = beat_valid[addr_beat];
    assign beat_wr       = fill_hit && collecting && !line_mismatch && !dup_beat;
    assign fill_err      = fill_hit && (!collecting || line_mismatch || dup_beat);
    assign beat_onehot   = LINE_BEATS'(1) << addr_beat;
    assign line_done     = &(beat_valid | beat_onehot);
    assign deliver_fire  = (state == FILL_DELIVER) && l2_l2rcv_fill_ready;
    assign deliver_last  = deliver_fire && (deliver_beat == BEAT_W'(LINE_BEATS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            FILL_IDLE: begin
                if (beat_wr) begin
                    next_state = FILL_COLLECT;
                end
            end
            FILL_COLLECT: begin
                if (beat_wr && line_done) begin
                    next_state = FILL_DELIVER;
                end
            end
            FILL_DELIVER: begin
                if (deliver_last) begin
                    next_state = FILL_IDLE;
                end
            end
            default: next_state = FILL_IDLE;
        endcase
    end

    // Output logic: fill outputs zero outside DELIVER.
    always_comb begin
        l2rcv_l2_fill_valid = 1'b0;
        l2rcv_l2_fill_addr  = '0;
        l2rcv_l2_fill_beat  = '0;
        l2rcv_l2_fill_data  = '0;
        if (state == FILL_DELIVER) begin
            l2rcv_l2_fill_valid = 1'b1;
            l2rcv_l2_fill_addr  = line_q;
            l2rcv_l2_fill_beat  = deliver_beat;
            l2rcv_l2_fill_data  = line_buf[deliver_beat];
        end
    end

    // Line buffer data; beat_valid tracks which entries are meaningful.
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            line_buf[addr_beat] <= bus_data;
        end
    end

    // Beat bookkeeping, latched line, delivery pointer and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_valid   <= '0;
            line_q       <= '0;
            deliver_beat <= '0;
            err_q        <= 1'b0;
        end else begin
            if (beat_wr) begin
                beat_valid <= beat_valid | beat_onehot;
                if (state == FILL_IDLE) begin
                    line_q <= addr_line;
                end
            end
            if (deliver_fire) begin
                deliver_beat <= BEAT_W'(deliver_beat + 1'b1);
            end
            if (deliver_last) begin
                beat_valid <= '0;
            end
            if (fill_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign l2rcv_err = err_q;

`ifdef L2RCV_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fills  <= '0;
            perf_snoops <= '0;
            perf_nacks  <= '0;
        end else begin
            if (deliver_last) begin
                perf_fills <= sat_inc(perf_fills);
            end
            if (snq_push) begin
                perf_snoops <= sat_inc(perf_snoops);
            end
            if (l2rcv_bus_nack) begin
                perf_nacks <= sat_inc(perf_nacks);
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2rcv.sv
// tb_l2rcv: directed bench for l2rcv (AGENT_ID=0, SNP_DEPTH=4).
module tb_l2rcv;
    import l2rcv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_valid;
    logic        bus_nack;
    logic        ext_nack;
    logic [2:0]  bus_cmd;
    logic [4:0]  bus_tag;
    logic [29:0] bus_addr;
    logic [63:0] bus_data;
    logic        l2rcv_bus_nack;
    logic        fill_valid;
    logic [25:0] fill_addr;
    logic [2:0]  fill_beat;
    logic [63:0] fill_data;
    logic        fill_ready;
    logic        snp_valid;
    logic [2:0]  snp_cmd;
    logic [25:0] snp_addr;
    logic        snp_ready;
    logic        err;
`ifdef L2RCV_PERF_EN
    logic [15:0] perf_fills;
    logic [15:0] perf_snoops;
    logic [15:0] perf_nacks;
`endif

    int checks   = 0;
    int failures = 0;
    int ord [8]  = '{7, 0, 3, 1, 6, 2, 5, 4};

    always #5 clk = ~clk;

    // Wired-OR bus NACK includes our own contribution.
    assign bus_nack = ext_nack | l2rcv_bus_nack;

    l2rcv #(.AGENT_ID(2'd0), .SNP_DEPTH(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus_valid           (bus_valid),
        .bus_nack            (bus_nack),
        .bus_cmd             (bus_cmd),
        .bus_tag             (bus_tag),
        .bus_addr            (bus_addr),
        .bus_data            (bus_data),
        .l2rcv_bus_nack      (l2rcv_bus_nack),
        .l2rcv_l2_fill_valid (fill_valid),
        .l2rcv_l2_fill_addr  (fill_addr),
        .l2rcv_l2_fill_beat  (fill_beat),
        .l2rcv_l2_fill_data  (fill_data),
        .l2_l2rcv_fill_ready (fill_ready),
        .l2rcv_l2_snp_valid  (snp_valid),
        .l2rcv_l2_snp_cmd    (snp_cmd),
        .l2rcv_l2_snp_addr   (snp_addr),
        .l2_l2rcv_snp_ready  (snp_ready),
        .l2rcv_err           (err)
`ifdef L2RCV_PERF_EN
        ,
        .perf_fills          (perf_fills),
        .perf_snoops         (perf_snoops),
        .perf_nacks          (perf_nacks)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] mk_addr(input logic [25:0] line, input logic [2:0] beat);
        return {line, beat, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_drive(input logic [2:0] cmd, input logic [4:0] tag,
                             input logic [29:0] addr, input logic [63:0] data);
        bus_valid = 1'b1;
        bus_cmd   = cmd;
        bus_tag   = tag;
        bus_addr  = addr;
        bus_data  = data;
    endtask

    task automatic bus_idle();
        bus_valid = 1'b0;
        bus_cmd   = 3'd0;
        bus_tag   = 5'd0;
        bus_addr  = 30'd0;
        bus_data  = 64'd0;
    endtask

    task automatic send(input logic [2:0] cmd, input logic [4:0] tag,
                        input logic [29:0] addr, input logic [63:0] data);
        bus_drive(cmd, tag, addr, data);
        tick();
        bus_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        int  exp_beat;
        int  seen;
        logic fire;

        rst        = 1'b1;
        ext_nack   = 1'b0;
        fill_ready = 1'b0;
        snp_ready  = 1'b0;
        bus_idle();
        tick();
        tick();

        // Reset state
        check("rst_fill_valid", 64'(fill_valid), 64'd0);
        check("rst_snp_valid",  64'(snp_valid),  64'd0);
        check("rst_err",        64'(err),        64'd0);
        check("rst_fill_data",  fill_data,       64'd0);
        check("rst_fill_addr",  64'(fill_addr),  64'd0);
        rst = 1'b0;
        tick();

        // In-order fill, ready held high
        fill_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(CMD_RESP, {2'd0, 3'd2}, mk_addr(26'h1234, 3'(i)), 64'(i));
        end
        for (int i = 0; i < 8; i++) begin
            check("inord_valid", 64'(fill_valid), 64'd1);
            check("inord_beat",  64'(fill_beat),  64'(i));
            check("inord_data",  fill_data,       64'(i));
            check("inord_addr",  64'(fill_addr),  64'h1234);
            tick();
        end
        check("inord_done", 64'(fill_valid), 64'd0);
        check("inord_err",  64'(err),        64'd0);

        // Out-of-order fill, ready toggling
        fill_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send(CMD_RESP, {2'd0, 3'd3}, mk_addr(26'h0ABC, 3'(ord[k])), 64'h100 + 64'(ord[k]));
        end
        exp_beat = 0;
        for (int c = 0; c < 40 && exp_beat < 8; c++) begin
            check("ooo_valid", 64'(fill_valid), 64'd1);
            check("ooo_beat",  64'(fill_beat),  64'(exp_beat));
            check("ooo_data",  fill_data,       64'h100 + 64'(exp_beat));
            check("ooo_addr",  64'(fill_addr),  64'h0ABC);
            fill_ready = (c % 2 == 1);
            fire       = fill_valid && fill_ready;
            tick();
            if (fire) exp_beat++;
        end
        check("ooo_count", 64'(exp_beat), 64'd8);
        check("ooo_done",  64'(fill_valid), 64'd0);
        check("ooo_err",   64'(err), 64'd0);

        // Snoop overflow: four queue, fifth NACKed
        snp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus_drive(CMD_RD, {2'd1, 3'(k)}, mk_addr(26'h200 + 26'(k), 3'd0), 64'd0);
            #2;
            check("ovf_nack", 64'(l2rcv_bus_nack), (k == 4) ? 64'd1 : 64'd0);
            tick();
            bus_idle();
        end
        check("ovf_valid", 64'(snp_valid), 64'd1);
        check("ovf_cmd",   64'(snp_cmd),   64'(CMD_RD));
        check("ovf_head",  64'(snp_addr),  64'h200);

        // Push while full with simultaneous pop: still NACKed
        bus_drive(CMD_RD, {2'd1, 3'd7}, mk_addr(26'h2FF, 3'd0), 64'd0);
        snp_ready = 1'b1;
        #2;
        check("fullpop_nack", 64'(l2rcv_bus_nack), 64'd1);
        check("fullpop_head", 64'(snp_addr), 64'h200);
        tick();
        bus_idle();
        for (int k = 1; k < 4; k++) begin
            check("drain_valid", 64'(snp_valid), 64'd1);
            check("drain_cmd",   64'(snp_cmd),   64'(CMD_RD));
            check("drain_addr",  64'(snp_addr),  64'h200 + 64'(k));
            tick();
        end
        check("drain_empty", 64'(snp_valid), 64'd0);

        // Externally NACKed INV is not queued
        bus_drive(CMD_INV, {2'd2, 3'd1}, mk_addr(26'h300, 3'd0), 64'd0);
        ext_nack = 1'b1;
        #2;
        check("extnack_own", 64'(l2rcv_bus_nack), 64'd0);
        tick();
        bus_idle();
        ext_nack = 1'b0;
        check("extnack_noq", 64'(snp_valid), 64'd0);

        // Own-tag RD ignored
        snp_ready = 1'b0;
        send(CMD_RD, {2'd0, 3'd4}, mk_addr(26'h310, 3'd0), 64'd0);
        check("owntag_noq", 64'(snp_valid), 64'd0);

        // WB burst from agent 3 yields exactly one snoop
        for (int b = 0; b < 8; b++) begin
            send(CMD_WB, {2'd3, 3'd5}, mk_addr(26'h3AA, 3'(b)), 64'hDEAD0000 + 64'(b));
        end
        check("wb_valid", 64'(snp_valid), 64'd1);
        check("wb_cmd",   64'(snp_cmd),   64'(CMD_WB));
        check("wb_addr",  64'(snp_addr),  64'h3AA);
        snp_ready = 1'b1;
        tick();
        check("wb_single", 64'(snp_valid), 64'd0);

        // RESP burst for another agent: neither snoop nor fill
        for (int b = 0; b < 8; b++) begin
            send(CMD_RESP, {2'd1, 3'd0}, mk_addr(26'h3BB, 3'(b)), 64'(b));
        end
        check("foreign_resp_snp",  64'(snp_valid),  64'd0);
        check("foreign_resp_fill", 64'(fill_valid), 64'd0);

        // Matching RESP during DELIVER: dropped, sticky error
        fill_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(CMD_RESP, {2'd0, 3'd1}, mk_addr(26'h0055, 3'(i)), 64'h200 + 64'(i));
        end
        check("err_pre_valid", 64'(fill_valid), 64'd1);
        check("err_pre",       64'(err),        64'd0);
        for (int i = 0; i < 8; i++) begin
            send(CMD_RESP, {2'd0, 3'd6}, mk_addr(26'h0066, 3'(i)), 64'h900 + 64'(i));
        end
        check("err_set",       64'(err),       64'd1);
        check("err_hold_beat", 64'(fill_beat), 64'd0);
        check("err_hold_data", fill_data,      64'h200);
        fill_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("err_deliver", fill_data, 64'h200 + 64'(i));
            tick();
        end
        check("err_done",   64'(fill_valid), 64'd0);
        check("err_sticky", 64'(err),        64'd1);

        // Reset mid-COLLECT discards the partial line
        for (int i = 0; i < 3; i++) begin
            send(CMD_RESP, {2'd0, 3'd2}, mk_addr(26'h0077, 3'(i)), 64'h700 + 64'(i));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_err",   64'(err),        64'd0);
        check("rst2_fill",  64'(fill_valid), 64'd0);
        check("rst2_data",  fill_data,       64'd0);
        check("rst2_snp",   64'(snp_valid),  64'd0);
        for (int i = 3; i < 8; i++) begin
            send(CMD_RESP, {2'd0, 3'd2}, mk_addr(26'h0077, 3'(i)), 64'h700 + 64'(i));
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (fill_valid) seen++;
            tick();
        end
        check("rst2_no_fill", 64'(seen), 64'd0);
        check("rst2_err_end", 64'(err),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
